// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser.
//   state_t      : parser FSM states
//   ERR_*        : values reported on o_err_code
//   DEF_*KEY     : default opcode bytes ('e' = edit, 'v' = view)
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HEX  = 2'd1;
    localparam logic [1:0] ERR_OVR  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] DEF_EDITKEY = 8'h65;
    localparam logic [7:0] DEF_VIEWKEY = 8'h76;

endpackage

// File: rtl/uart_cmd_parser_hex_ascii_decode.sv
// ASCII hex digit to nibble decoder (combinational).
//   ascii : input character
//   nib   : decoded value, 0 when not a hex digit
//   valid : ascii is one of 0-9, a-f, A-F
module hex_ascii_decode (
    input  logic [7:0] ascii,
    output logic [3:0] nib,
    output logic       valid
);

    always_comb begin
        nib   = 4'd0;
        valid = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nib   = ascii[3:0];
            valid = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10
            nib   = ascii[3:0] + 4'd9;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command frame parser.
//   edit frame: EDITKEY, ADDR_W/8 raw address bytes (MSB first), DATA_W/4 hex digits
//   view frame: VIEWKEY, ADDR_W/8 raw address bytes
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_new_byte, i_rx_byte     : byte strobe and data from the UART receiver
//   o_cmd_valid, i_cmd_ready  : command handshake; o_cmd/o_waddr/o_wdata hold while valid
//   o_err, o_err_code         : one-cycle error pulse; code held until the next error
//   f_editing, f_viewing      : frame-collection status flags
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for an opcode byte, other bytes ignored
// ST_ADDR  | collecting raw address bytes
// ST_DATA  | collecting hex data digits (edit only)
// ST_ISSUE | command presented, waiting for i_cmd_ready
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] EDITKEY     = DEF_EDITKEY,
    parameter logic [7:0] VIEWKEY     = DEF_VIEWKEY,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_new_byte,
    input  logic [7:0]        i_rx_byte,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic [7:0]        o_cmd,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic              f_editing,
    output logic              f_viewing
);

    localparam int NDIG  = DATA_W / 4;
    localparam int NAB   = ADDR_W / 8;
    localparam int DIG_W = $clog2(NDIG + 1);
    localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic             AB_LAST  = 1'(NAB - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NDIG - 1);
    // Loaded on each byte and fired at 1, so the error pulse lands exactly
    // TIMEOUT_CYC cycles after the last strobe.
    localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT_CYC > 1) ? TMO_W'(TIMEOUT_CYC - 1) : '0;

    state_t            state_q, state_d;
    logic              mode_edit_q, mode_edit_d;
    logic              ab_cnt_q, ab_cnt_d;
    logic [DIG_W-1:0]  dig_cnt_q, dig_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [3:0] nib;
    logic       nib_ok;
    logic       tmo_fire;

    hex_ascii_decode u_hex (
        .ascii (i_rx_byte),
        .nib   (nib),
        .valid (nib_ok)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            mode_edit_q <= 1'b0;
            ab_cnt_q    <= 1'b0;
            dig_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cmd_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            mode_edit_q <= mode_edit_d;
            ab_cnt_q    <= ab_cnt_d;
            dig_cnt_q   <= dig_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cmd_q       <= cmd_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign tmo_fire = (TIMEOUT_CYC != 0) && !i_new_byte && (tmo_cnt_q <= TMO_W'(1));

    always_comb begin
        state_d     = state_q;
        mode_edit_d = mode_edit_q;
        ab_cnt_d    = ab_cnt_q;
        dig_cnt_d   = dig_cnt_q;
        cmd_d       = cmd_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;

        // Free-running outside frames; only consulted in ST_ADDR/ST_DATA.
        if (i_new_byte)
            tmo_cnt_d = TMO_LOAD;
        else if (tmo_cnt_q != '0)
            tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
        else
            tmo_cnt_d = tmo_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_new_byte && i_rx_byte == EDITKEY) begin
                    state_d     = ST_ADDR;
                    mode_edit_d = 1'b1;
                    cmd_d       = i_rx_byte;
                    ab_cnt_d    = 1'b0;
                end else if (i_new_byte && i_rx_byte == VIEWKEY) begin
                    state_d     = ST_ADDR;
                    mode_edit_d = 1'b0;
                    cmd_d       = i_rx_byte;
                    ab_cnt_d    = 1'b0;
                    wdata_d     = '0;
                end
            end

            ST_ADDR: begin
                if (i_new_byte) begin
                    waddr_d  = ADDR_W'({waddr_q, i_rx_byte});
                    ab_cnt_d = ab_cnt_q + 1'b1;
                    if (ab_cnt_q == AB_LAST) begin
                        if (mode_edit_q) begin
                            state_d   = ST_DATA;
                            wdata_d   = '0;
                            dig_cnt_d = '0;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end else if (tmo_fire) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                end
            end

            ST_DATA: begin
                if (i_new_byte) begin
                    if (nib_ok) begin
                        wdata_d   = DATA_W'({wdata_q, nib});
                        dig_cnt_d = dig_cnt_q + DIG_W'(1);
                        if (dig_cnt_q == DIG_LAST)
                            state_d = ST_ISSUE;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_HEX;
                    end
                end else if (tmo_fire) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                end
            end

            ST_ISSUE: begin
                // A byte here is lost; the pending command is left untouched.
                if (i_new_byte) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVR;
                end
                if (i_cmd_ready)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_cmd_valid = (state_q == ST_ISSUE);
    assign o_cmd       = cmd_q;
    assign o_waddr     = waddr_q;
    assign o_wdata     = wdata_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign f_editing   = mode_edit_q && (state_q == ST_ADDR || state_q == ST_DATA);
    assign f_viewing   = !mode_edit_q && (state_q == ST_ADDR);

endmodule
